// File: rtl/seven_seg_scroller_if.sv
// ----------------------------------------------------------------------------
// seven_seg_scroller_if
// Groups the scroller's control inputs and display outputs into one bundle.
//   master : drives step_clk, run, restart, msg (and dir); observes an, seg, pos
//   slave  : the scroller itself
// Optional feature macro: SCROLL_REVERSE_EN adds the 1-bit dir signal.
// ----------------------------------------------------------------------------
interface seven_seg_scroller_if #(
  parameter int MSG_LEN = 16
);
  localparam int PW = $clog2(MSG_LEN);

  logic                   step_clk;  // slow step clock level from the divider
  logic                   run;       // 1 = scroll on step edges
  logic                   restart;   // synchronous return to position 0
  logic [4*MSG_LEN-1:0]   msg;       // hex characters, char i = msg[4*i+3:4*i]
`ifdef SCROLL_REVERSE_EN
  logic                   dir;       // 1 = step backwards
`endif
  logic [3:0]             an;        // anode enables, active-low
  logic [6:0]             seg;       // {g,f,e,d,c,b,a}, active-low
  logic [PW-1:0]          pos;       // character index on the leftmost digit

`ifdef SCROLL_REVERSE_EN
  modport master (output step_clk, run, restart, msg, dir, input an, seg, pos);
  modport slave  (input step_clk, run, restart, msg, dir, output an, seg, pos);
`else
  modport master (output step_clk, run, restart, msg, input an, seg, pos);
  modport slave  (input step_clk, run, restart, msg, output an, seg, pos);
`endif
endinterface

// File: rtl/seven_seg_scroller.sv
// ----------------------------------------------------------------------------
// seven_seg_scroller
// Scrolls a hex message across a 4-digit active-low seven-segment display.
// Each rising edge of the slow step clock advances the window by one
// character while a free-running refresh counter multiplexes the anodes.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : seven_seg_scroller_if.slave (step_clk, run, restart, msg, [dir],
//            an, seg, pos)
// Optional feature macro: SCROLL_REVERSE_EN (adds bus.dir for backward steps).
// ----------------------------------------------------------------------------
module seven_seg_scroller #(
  parameter int MSG_LEN      = 16,
  parameter int REFRESH_BITS = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scroller_if.slave   bus
);
  localparam int PW = $clog2(MSG_LEN);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_sync3;
  logic                    w_step_pulse;
  logic [PW-1:0]           r_pos;
  logic [PW-1:0]           w_pos_step;
  logic [PW-1:0]           w_pos_next;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [1:0]              w_digit;
  logic [PW-1:0]           w_char_idx;
  logic [3:0]              w_char;
  logic [3:0]              r_an;
  logic [6:0]              r_seg;

  // Hex to active-low {g,f,e,d,c,b,a}; unknown codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    logic [6:0] segs;
    case (hex)
      4'h0:    segs = 7'h40;
      4'h1:    segs = 7'h79;
      4'h2:    segs = 7'h24;
      4'h3:    segs = 7'h30;
      4'h4:    segs = 7'h19;
      4'h5:    segs = 7'h12;
      4'h6:    segs = 7'h02;
      4'h7:    segs = 7'h78;
      4'h8:    segs = 7'h00;
      4'h9:    segs = 7'h10;
      4'hA:    segs = 7'h08;
      4'hB:    segs = 7'h03;
      4'hC:    segs = 7'h46;
      4'hD:    segs = 7'h21;
      4'hE:    segs = 7'h06;
      4'hF:    segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
    return segs;
  endfunction

  // Rising edge of the synchronised step clock, one clk wide.
  assign w_step_pulse = r_sync2 & ~r_sync3;

  // Digit 0 is the rightmost; the leftmost (digit 3) shows pos, so the
  // message reads left-to-right.
  assign w_digit    = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_char_idx = r_pos + PW'(3) - PW'(w_digit);
  assign w_char     = bus.msg[4*w_char_idx +: 4];

  // Synchroniser for step_clk plus the previous-sample flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= bus.step_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // FSM state and scroll position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STOP;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
    end
  end

  // Next state and next position; a pulse arriving while still in STOP
  // (including the STOP->RUN cycle) is dropped.
  always_comb begin
    w_state_next = r_state;
    w_pos_step   = r_pos;
    case (r_state)
      ST_STOP: begin
        w_pos_step = r_pos;
        if (bus.run) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      ST_RUN: begin
        if (w_step_pulse) begin
`ifdef SCROLL_REVERSE_EN
          if (bus.dir) begin
            w_pos_step = r_pos - PW'(1);
          end else begin
            w_pos_step = r_pos + PW'(1);
          end
`else
          w_pos_step = r_pos + PW'(1);
`endif
        end else begin
          w_pos_step = r_pos;
        end
        if (bus.run) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_STOP;
        w_pos_step   = r_pos;
      end
    endcase
    // restart wins over any step but leaves the state alone.
    w_pos_next = bus.restart ? '0 : w_pos_step;
  end

  // Free-running refresh counter; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
    end
  end

  // Registered anode/segment drive, one cycle behind digit select and pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= ~(4'b0001 << w_digit);
      r_seg <= seg_decode(w_char);
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.pos = r_pos;

endmodule

// File: tb/tb_seven_seg_scroller.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scroller
// Self-checking bench for seven_seg_scroller (MSG_LEN=16, REFRESH_BITS=4).
// A behavioural model tracks position, run state, step-edge history and the
// refresh count, and predicts an/seg/pos every cycle.
// ----------------------------------------------------------------------------
module tb_seven_seg_scroller;
  localparam logic [63:0] MSG_FIX = 64'hFEDCBA9876543210;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  // Behavioural model state
  int   m_pos;
  int   m_cnt;
  bit   m_run;
  bit   h0, h1, h2;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_scroller_if #(.MSG_LEN(16)) bus ();

  seven_seg_scroller #(.MSG_LEN(16), .REFRESH_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_cnt = 0;
    m_run = 1'b0;
    h0 = 1'b0;
    h1 = 1'b0;
    h2 = 1'b0;
  endtask

  // One clock cycle from negedge to negedge, with full output prediction.
  task automatic cyc();
    int d;
    int idx;
    bit pulse;
    bit back;
    logic [3:0] ea;
    logic [6:0] es;
    d   = (m_cnt / 4) % 4;
    ea  = ~(4'b0001 << d);
    idx = (m_pos + 3 - d) % 16;
    es  = seg_tab[bus.msg[4*idx +: 4]];
    back = 1'b0;
`ifdef SCROLL_REVERSE_EN
    back = bus.dir;
`endif
    @(posedge clk);
    pulse = h1 & ~h2;
    if (bus.restart) m_pos = 0;
    else if (m_run && pulse) m_pos = back ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
    m_run = bus.run;
    h2 = h1;
    h1 = h0;
    h0 = bus.step_clk;
    m_cnt = (m_cnt + 1) % 16;
    @(negedge clk);
    chk("an", {60'd0, bus.an}, {60'd0, ea});
    chk("seg", {57'd0, bus.seg}, {57'd0, es});
    chk("pos", {60'd0, bus.pos}, {60'd0, 4'(m_pos)});
  endtask

  task automatic step_edge(input int hi, input int lo);
    bus.step_clk = 1'b1;
    repeat (hi) cyc();
    bus.step_clk = 1'b0;
    repeat (lo) cyc();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst_n = 1'b0;
    bus.step_clk = 1'b0;
    bus.run      = 1'b0;
    bus.restart  = 1'b0;
    bus.msg      = MSG_FIX;
`ifdef SCROLL_REVERSE_EN
    bus.dir      = 1'b0;
`endif

    // 1. reset held, then release: scan runs, pos stays 0
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_an", {60'd0, bus.an}, 64'hF);
      chk("rst_seg", {57'd0, bus.seg}, 64'h7F);
      chk("rst_pos", {60'd0, bus.pos}, 64'h0);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (20) cyc();

    // 2. single step: latency of three edges after the rise
    bus.run = 1'b1;
    repeat (2) cyc();
    bus.step_clk = 1'b1;
    cyc();
    cyc();
    chk("lat_pre", {60'd0, bus.pos}, 64'd0);
    cyc();
    chk("lat_post", {60'd0, bus.pos}, 64'd1);
    repeat (29) cyc();
    bus.step_clk = 1'b0;
    repeat (8) cyc();
    chk("single_inc", {60'd0, bus.pos}, 64'd1);
    repeat (16) cyc();

    // 3. fifteen more edges wrap back to 0
    repeat (15) step_edge(4, 4);
    chk("wrap", {60'd0, bus.pos}, 64'd0);

    // 4. frozen when run=0; restart beats a simultaneous pulse, state stays RUN
    bus.run = 1'b0;
    repeat (2) cyc();
    repeat (3) step_edge(3, 3);
    chk("frozen", {60'd0, bus.pos}, 64'd0);
    bus.run = 1'b1;
    repeat (2) cyc();
    step_edge(3, 3);
    chk("run_again", {60'd0, bus.pos}, 64'd1);
    bus.step_clk = 1'b1;
    cyc();
    cyc();
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    chk("restart_prio", {60'd0, bus.pos}, 64'd0);
    bus.step_clk = 1'b0;
    repeat (4) cyc();
    step_edge(3, 3);
    chk("still_run", {60'd0, bus.pos}, 64'd1);

    // 5. randomized message / run / restart / step timing
    for (int i = 0; i < 40; i++) begin
      bus.msg     = {$urandom, $urandom};
      bus.run     = ($urandom_range(0, 3) != 0);
      bus.restart = ($urandom_range(0, 9) == 0);
      cyc();
      bus.restart = 1'b0;
      step_edge($urandom_range(1, 6), $urandom_range(1, 6));
    end

    // 6. reach pos 9 then assert reset asynchronously mid-cycle
    bus.msg = MSG_FIX;
    bus.run = 1'b1;
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    repeat (2) cyc();
    repeat (9) step_edge(3, 3);
    chk("pos9", {60'd0, bus.pos}, 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {60'd0, bus.an}, 64'hF);
    chk("async_seg", {57'd0, bus.seg}, 64'h7F);
    chk("async_pos", {60'd0, bus.pos}, 64'h0);
    @(negedge clk);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (8) cyc();

`ifdef SCROLL_REVERSE_EN
    // 7. backward step from 0 wraps to 15, forward step returns to 0
    repeat (2) cyc();
    bus.dir = 1'b1;
    step_edge(3, 3);
    chk("rev_wrap", {60'd0, bus.pos}, 64'd15);
    bus.dir = 1'b0;
    step_edge(3, 3);
    chk("fwd_back", {60'd0, bus.pos}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
